// File: rtl/ifns_12bit_serial_encoder.sv
// Sequential 12-bit IFNS encoder: resolves one of 17 codeword digits per clock,
// MSB (d17) first, by greedy subtraction of the fixed digit weights.
//
// Handshakes: a word moves across a port on a rising edge where valid and
// ready are both 1. The producer holds valid (and its data) until that edge.
// in_ready depends only on the current state and out_ready, never on in_valid.
// out_valid/out_code are registered and out_code is held while out_valid=1
// and out_ready=0.
module ifns_12bit_serial_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] out_code,
    output logic [1:0]  dbg_state,
    output logic [4:0]  dbg_step,
    output logic [11:0] dbg_remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_nx;
    logic [11:0] rem_q, rem_nx;
    logic [4:0]  step_q, step_nx;
    logic [16:0] work_q, work_nx;
    logic [16:0] code_nx;
    logic        valid_nx;
    logic [11:0] weight;
    logic [16:0] step_mask;
    logic        take;

    // Weight of digit d(s+1); the table skips 1597, so d17 is 2584.
    function automatic logic [11:0] digit_weight(input logic [4:0] s);
        logic [11:0] w;
        case (s)
            5'd0:    w = 12'd1;
            5'd1:    w = 12'd1;
            5'd2:    w = 12'd2;
            5'd3:    w = 12'd3;
            5'd4:    w = 12'd5;
            5'd5:    w = 12'd8;
            5'd6:    w = 12'd13;
            5'd7:    w = 12'd21;
            5'd8:    w = 12'd34;
            5'd9:    w = 12'd55;
            5'd10:   w = 12'd89;
            5'd11:   w = 12'd144;
            5'd12:   w = 12'd233;
            5'd13:   w = 12'd377;
            5'd14:   w = 12'd610;
            5'd15:   w = 12'd987;
            5'd16:   w = 12'd2584;
            default: w = 12'd0;
        endcase
        return w;
    endfunction

    assign weight    = digit_weight(step_q);
    assign step_mask = 17'd1 << step_q;
    assign take      = (rem_q >= weight);

    assign dbg_state     = state_q;
    assign dbg_step      = step_q;
    assign dbg_remainder = rem_q;

    // Next-state, datapath updates and in_ready for the IDLE/BUSY/DONE walk.
    always_comb begin
        state_nx = state_q;
        rem_nx   = rem_q;
        step_nx  = step_q;
        work_nx  = work_q;
        code_nx  = out_code;
        valid_nx = out_valid;
        in_ready = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    rem_nx   = in_value;
                    work_nx  = '0;
                    step_nx  = 5'd16;
                    state_nx = BUSY;
                end
            end

            BUSY: begin
                if (take) begin
                    work_nx = work_q | step_mask;
                    rem_nx  = rem_q - weight;
                end
                if (step_q == 5'd0) begin
                    code_nx  = work_nx;
                    valid_nx = 1'b1;
                    state_nx = DONE;
                end else begin
                    step_nx = step_q - 5'd1;
                end
            end

            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    valid_nx = 1'b0;
                    if (in_valid) begin
                        rem_nx   = in_value;
                        work_nx  = '0;
                        step_nx  = 5'd16;
                        state_nx = BUSY;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end

            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            step_q    <= '0;
            work_q    <= '0;
            out_code  <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_nx;
            rem_q     <= rem_nx;
            step_q    <= step_nx;
            work_q    <= work_nx;
            out_code  <= code_nx;
            out_valid <= valid_nx;
        end
    end

    // The greedy walk must have consumed the whole value by the last digit.
    assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == BUSY && step_q == 5'd0) |-> (rem_nx == 12'd0));

endmodule

// File: tb/tb_ifns_12bit_serial_encoder.sv
// Self-checking bench for ifns_12bit_serial_encoder: directed vector table,
// multi-cycle corner sequences, exhaustive stream and randomized throttling.
module tb_ifns_12bit_serial_encoder;

  localparam int WT [17] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987, 2584};

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_code;
  logic [1:0]  dbg_state;
  logic [4:0]  dbg_step;
  logic [11:0] dbg_remainder;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  bit  mon_en = 0;
  bit  stream_mode = 0;
  bit  rand_ready = 0;
  int  sent = 0;
  int  recv = 0;
  int  cyc = 0;
  int  last_cyc = -1;

  typedef struct {
    logic [11:0] value;
    logic [16:0] code;
  } vec_t;

  vec_t vecs [11];

  ifns_12bit_serial_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_value      (in_value),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_code      (out_code),
    .dbg_state     (dbg_state),
    .dbg_step      (dbg_step),
    .dbg_remainder (dbg_remainder)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: repeatedly take the largest unused digit weight that fits.
  function automatic logic [16:0] model_encode(input int v);
    logic [16:0] c;
    int r;
    bit found;
    c = '0;
    r = v;
    while (r > 0) begin
      found = 0;
      for (int j = 16; j >= 0; j--) begin
        if (!found && !c[j] && WT[j] <= r) begin
          c[j] = 1'b1;
          r = r - WT[j];
          found = 1;
        end
      end
      if (!found) break;
    end
    return c;
  endfunction

  function automatic int decode(input logic [16:0] c);
    int s;
    s = 0;
    for (int k = 0; k < 17; k++) if (c[k]) s += WT[k];
    return s;
  endfunction

  function automatic bit no_adjacent(input logic [16:0] c);
    for (int k = 1; k < 15; k++) if (c[k] && c[k + 1]) return 0;
    return 1;
  endfunction

  // Below 1597 and from 2584 up the remainder stays under the missing weight
  // 1597, so the greedy code is a true Zeckendorf form; in between it is not.
  function automatic bit zeck_range(input int v);
    return (v < 1597) || (v >= 2584);
  endfunction

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_word(input logic [11:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in_value = v;
    #1;
    check("accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_value = 12'($urandom_range(0, 4095));
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_word();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("valid_drop", out_valid, 0);
    check("idle_ready", in_ready, 1);
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic ready_randomizer();
    forever begin
      @(negedge clk);
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // scoreboard / monitor: samples 2 time units after each falling edge
  task automatic monitor();
    bit prev_hold;
    logic [16:0] prev_code;
    logic [11:0] v;
    prev_hold = 0;
    prev_code = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        prev_hold = 0;
        continue;
      end
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_code", out_code, prev_code);
      end
      prev_hold = out_valid && !out_ready;
      prev_code = out_code;
      if (mon_en && out_valid && out_ready) begin
        recv++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", out_code, 0);
        end else begin
          v = exp_q.pop_front();
          check("code", out_code, model_encode(int'(v)));
          check("round_trip", decode(out_code), v);
          if (zeck_range(int'(v))) begin
            check("zeckendorf", no_adjacent(out_code), 1);
            check("d1_clear", out_code[0], 0);
          end
          if (stream_mode) begin
            if (last_cyc >= 0) check("spacing", cyc - last_cyc, 18);
            last_cyc = cyc;
          end
        end
      end
    end
  endtask

  initial begin
    int lat;
    int g;
    int next;
    int gap;
    bit acc;
    logic [11:0] v;

    vecs[0]  = '{12'd0,    17'h00000};
    vecs[1]  = '{12'd1,    17'h00002};
    vecs[2]  = '{12'd2,    17'h00004};
    vecs[3]  = '{12'd3,    17'h00008};
    vecs[4]  = '{12'd4,    17'h0000A};
    vecs[5]  = '{12'd12,   17'h0002A};
    vecs[6]  = '{12'd1000, 17'h08040};
    vecs[7]  = '{12'd1597, 17'h0C000};
    vecs[8]  = '{12'd2583, 17'h0FFFF};
    vecs[9]  = '{12'd2584, 17'h10000};
    vecs[10] = '{12'd4095, 17'h1A808};

    fork
      monitor();
      ready_randomizer();
    join_none

    // reset state
    do_reset();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_code", out_code, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", dbg_state, 0);
    check("rst_remainder", dbg_remainder, 0);
    check("rst_step", dbg_step, 0);

    // directed vector table
    for (int i = 0; i < 11; i++) begin
      start_word(vecs[i].value);
      wait_result(lat);
      check("vec_latency", lat, 17);
      check("vec_code", out_code, vecs[i].code);
      check("vec_remainder", dbg_remainder, 0);
      check("vec_step", dbg_step, 0);
      release_word();
    end

    // 4095 held with out_ready low for 10 cycles
    start_word(12'd4095);
    wait_result(lat);
    check("hold_latency", lat, 17);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("stall_valid", out_valid, 1);
      check("stall_code", out_code, 17'h1A808);
      check("stall_in_ready", in_ready, 0);
    end
    release_word();

    // reset in the middle of BUSY at step 8
    start_word(12'd4095);
    g = 0;
    while (dbg_step != 5'd8 && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("reach_step8", dbg_step, 8);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_word(12'd5);
    wait_result(lat);
    check("abort_latency", lat, 17);
    check("abort_next_code", out_code, 17'h00010);
    release_word();

    // exhaustive back-to-back stream
    mon_en = 1;
    stream_mode = 1;
    last_cyc = -1;
    sent = 0;
    recv = 0;
    out_ready = 1'b1;
    next = 0;
    g = 0;
    while (next < 4096 && g < 80000) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_value = 12'(next);
      #1;
      if (in_ready) begin
        exp_q.push_back(12'(next));
        next++;
        sent++;
      end
      g++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_drain("stream_drain");
    check("stream_sent", sent, 4096);
    check("stream_recv", recv, 4096);
    stream_mode = 0;

    // randomized in_valid / out_ready throttling
    sent = 0;
    recv = 0;
    @(negedge clk);
    rand_ready = 1;
    for (int n = 0; n < 60; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      v = 12'($urandom_range(0, 4095));
      acc = 0;
      g = 0;
      while (!acc && g < 200) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_value = v;
        #1;
        if (in_ready) begin
          acc = 1;
          exp_q.push_back(v);
          sent++;
        end
        g++;
      end
      check("rand_accept", acc, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rand_ready = 0;
    out_ready = 1'b1;
    wait_drain("rand_drain");
    check("rand_count", recv, sent);
    mon_en = 0;
    @(negedge clk);
    out_ready = 1'b0;

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
